// File: rtl/ex_stage_mdu.sv
// Execute stage: single-cycle ALU into EX/MEM plus an iterative
// multiply/divide unit that owns the HI/LO registers.
//
// Handshake: ID/EX offers an instruction with IDEX_valid_i. It is taken
// at a rising edge only when the MDU is idle (busy_o=0) and flush_i=0.
// While busy_o=1 the ID/EX contents are ignored and upstream must hold
// them unchanged, so a dependent MFHI/MFLO issues after the MDU finishes.

package ex_stage_mdu_pkg;
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;

   localparam logic [4:0] AUX_SLL  = 5'd0;
   localparam logic [4:0] AUX_SRL  = 5'd2;
   localparam logic [4:0] AUX_SRA  = 5'd3;
   localparam logic [4:0] AUX_ADD  = 5'd8;
   localparam logic [4:0] AUX_SUB  = 5'd9;
   localparam logic [4:0] AUX_AND  = 5'd10;
   localparam logic [4:0] AUX_OR   = 5'd11;
   localparam logic [4:0] AUX_XOR  = 5'd12;
   localparam logic [4:0] AUX_NOR  = 5'd13;
   localparam logic [4:0] AUX_MFHI = 5'd16;
   localparam logic [4:0] AUX_MFLO = 5'd18;
   localparam logic [4:0] ALU_MULT  = 5'd24;
   localparam logic [4:0] ALU_MULTU = 5'd25;
   localparam logic [4:0] ALU_DIV   = 5'd26;
   localparam logic [4:0] ALU_DIVU  = 5'd27;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;
endpackage

module ex_stage_mdu
   import ex_stage_mdu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk_i,
   input  logic            n_rst_i,
   input  logic            flush_i,
   input  logic            IDEX_valid_i,
   input  logic [5:0]      IDEX_op_i,
   input  logic [4:0]      IDEX_aux_i,
   input  logic [4:0]      IDEX_shift_i,
   input  logic [XLEN-1:0] IDEX_a_i,
   input  logic [XLEN-1:0] IDEX_b_i,
   input  logic [15:0]     IDEX_imm_i,
   input  logic            IDEX_alu_src_i,
   input  logic [4:0]      IDEX_rd_i,
   input  logic            IDEX_reg_write_i,
   output logic            busy_o,
   output logic            EXMEM_valid_o,
   output logic [XLEN-1:0] EXMEM_alu_o,
   output logic [4:0]      EXMEM_rd_o,
   output logic            EXMEM_reg_write_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o,
   output logic [1:0]      dbg_state_o
);
   localparam int SH_W = $clog2(XLEN);

   mdu_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   mcand;      // multiplicand or divisor magnitude
   logic [XLEN-1:0]   acc_hi;     // partial product high / remainder
   logic [XLEN-1:0]   acc_lo;     // multiplier / dividend -> quotient
   logic [XLEN-1:0]   dividend_raw;
   logic              div_zero;
   logic              neg_q;
   logic              neg_r;

   logic [XLEN-1:0]   imm_ext;
   logic [XLEN-1:0]   op_b;
   logic [SH_W-1:0]   shamt;
   logic [XLEN-1:0]   alu_res;
   logic              is_mul;
   logic              is_div;
   logic              is_signed;
   logic              accept;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_sh;
   logic [XLEN:0]     div_diff;
   logic [XLEN-1:0]   step_hi;
   logic [XLEN-1:0]   step_lo;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   fin_hi;
   logic [XLEN-1:0]   fin_lo;

   assign imm_ext     = XLEN'($signed(IDEX_imm_i));
   assign op_b        = IDEX_alu_src_i ? imm_ext : IDEX_b_i;
   assign shamt       = SH_W'(IDEX_shift_i);
   assign accept      = IDEX_valid_i && (state == ST_IDLE) && !flush_i;
   assign a_mag       = (is_signed && IDEX_a_i[XLEN-1]) ? -IDEX_a_i : IDEX_a_i;
   assign b_mag       = (is_signed && IDEX_b_i[XLEN-1]) ? -IDEX_b_i : IDEX_b_i;
   assign dbg_state_o = state;

   // Decode and single-cycle ALU result; unknown encodings give all ones
   always_comb begin
      alu_res   = '1;
      is_mul    = 1'b0;
      is_div    = 1'b0;
      is_signed = 1'b0;
      case (IDEX_op_i)
         OP_R: begin
            case (IDEX_aux_i)
               AUX_ADD:   alu_res = IDEX_a_i + op_b;
               AUX_SUB:   alu_res = IDEX_a_i - op_b;
               AUX_AND:   alu_res = IDEX_a_i & op_b;
               AUX_OR:    alu_res = IDEX_a_i | op_b;
               AUX_XOR:   alu_res = IDEX_a_i ^ op_b;
               AUX_NOR:   alu_res = ~(IDEX_a_i | op_b);
               AUX_SLL:   alu_res = op_b << shamt;
               AUX_SRL:   alu_res = op_b >> shamt;
               AUX_SRA:   alu_res = XLEN'($signed(op_b) >>> shamt);
               AUX_MFHI:  alu_res = hi_o;
               AUX_MFLO:  alu_res = lo_o;
               ALU_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; alu_res = '0; end
               ALU_MULTU: begin is_mul = 1'b1; alu_res = '0; end
               ALU_DIV:   begin is_div = 1'b1; is_signed = 1'b1; alu_res = '0; end
               ALU_DIVU:  begin is_div = 1'b1; alu_res = '0; end
               default:   alu_res = '1;
            endcase
         end
         OP_ADDI: alu_res = IDEX_a_i + op_b;
         OP_ANDI: alu_res = IDEX_a_i & op_b;
         OP_ORI:  alu_res = IDEX_a_i | op_b;
         OP_XORI: alu_res = IDEX_a_i ^ op_b;
         default: alu_res = '1;
      endcase
   end

   // One MDU iteration plus the sign-corrected result of the final one
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
      div_sh   = {acc_hi, acc_lo[XLEN-1]};
      div_diff = div_sh - {1'b0, mcand};
      step_hi  = acc_hi;
      step_lo  = acc_lo;
      if (state == ST_MUL) begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      end else if (state == ST_DIV) begin
         if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            step_hi = div_sh[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b0};
         end
      end
      prod = {step_hi, step_lo};
      if (neg_q) prod = -prod;
      if (state == ST_MUL) begin
         fin_hi = prod[2*XLEN-1:XLEN];
         fin_lo = prod[XLEN-1:0];
      end else if (div_zero) begin
         fin_hi = dividend_raw;
         fin_lo = '1;
      end else begin
         fin_hi = neg_r ? -step_hi : step_hi;
         fin_lo = neg_q ? -step_lo : step_lo;
      end
   end

   // MDU control FSM, operand registers, HI/LO and the registered busy flag
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state        <= ST_IDLE;
         busy_o       <= 1'b0;
         cnt          <= '0;
         mcand        <= '0;
         acc_hi       <= '0;
         acc_lo       <= '0;
         dividend_raw <= '0;
         div_zero     <= 1'b0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         hi_o         <= '0;
         lo_o         <= '0;
      end else if (flush_i) begin
         state  <= ST_IDLE;
         busy_o <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && (is_mul || is_div)) begin
                  state        <= is_mul ? ST_MUL : ST_DIV;
                  busy_o       <= 1'b1;
                  cnt          <= '0;
                  mcand        <= is_mul ? a_mag : b_mag;
                  acc_hi       <= '0;
                  acc_lo       <= is_mul ? b_mag : a_mag;
                  dividend_raw <= IDEX_a_i;
                  div_zero     <= (IDEX_b_i == '0);
                  neg_q        <= is_signed && (IDEX_a_i[XLEN-1] ^ IDEX_b_i[XLEN-1]);
                  neg_r        <= is_signed && IDEX_a_i[XLEN-1];
               end
            end
            ST_MUL, ST_DIV: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(XLEN - 1)) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
                  cnt    <= '0;
                  hi_o   <= fin_hi;
                  lo_o   <= fin_lo;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   // EX/MEM register: ALU results on acceptance, bubbles otherwise
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         EXMEM_valid_o     <= 1'b0;
         EXMEM_alu_o       <= '0;
         EXMEM_rd_o        <= '0;
         EXMEM_reg_write_o <= 1'b0;
      end else if (accept && !is_mul && !is_div) begin
         EXMEM_valid_o     <= 1'b1;
         EXMEM_alu_o       <= alu_res;
         EXMEM_rd_o        <= IDEX_rd_i;
         EXMEM_reg_write_o <= IDEX_reg_write_i;
      end else begin
         EXMEM_valid_o     <= 1'b0;
         EXMEM_alu_o       <= '0;
         EXMEM_rd_o        <= '0;
         EXMEM_reg_write_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: a 32-bit instance for ALU, MDU, flush
// and reset behaviour, plus a 16-bit instance for the narrow multiply.
module tb_ex_stage_mdu;
   import ex_stage_mdu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic n_rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------- 32-bit instance ----------------
   logic        flush_i = 1'b0;
   logic        IDEX_valid_i = 1'b0;
   logic [5:0]  IDEX_op_i = '0;
   logic [4:0]  IDEX_aux_i = '0;
   logic [4:0]  IDEX_shift_i = '0;
   logic [31:0] IDEX_a_i = '0;
   logic [31:0] IDEX_b_i = '0;
   logic [15:0] IDEX_imm_i = '0;
   logic        IDEX_alu_src_i = 1'b0;
   logic [4:0]  IDEX_rd_i = '0;
   logic        IDEX_reg_write_i = 1'b0;
   logic        busy_o;
   logic        EXMEM_valid_o;
   logic [31:0] EXMEM_alu_o;
   logic [4:0]  EXMEM_rd_o;
   logic        EXMEM_reg_write_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [1:0]  dbg_state_o;

   ex_stage_mdu #(.XLEN(32)) dut (
      .clk_i(clk_i), .n_rst_i(n_rst_i), .flush_i(flush_i),
      .IDEX_valid_i(IDEX_valid_i), .IDEX_op_i(IDEX_op_i), .IDEX_aux_i(IDEX_aux_i),
      .IDEX_shift_i(IDEX_shift_i), .IDEX_a_i(IDEX_a_i), .IDEX_b_i(IDEX_b_i),
      .IDEX_imm_i(IDEX_imm_i), .IDEX_alu_src_i(IDEX_alu_src_i), .IDEX_rd_i(IDEX_rd_i),
      .IDEX_reg_write_i(IDEX_reg_write_i), .busy_o(busy_o),
      .EXMEM_valid_o(EXMEM_valid_o), .EXMEM_alu_o(EXMEM_alu_o), .EXMEM_rd_o(EXMEM_rd_o),
      .EXMEM_reg_write_o(EXMEM_reg_write_o), .hi_o(hi_o), .lo_o(lo_o),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- 16-bit instance ----------------
   logic        s_valid_i = 1'b0;
   logic [15:0] s_a = '0;
   logic [15:0] s_b = '0;
   logic        s_busy;
   logic        s_valid_o;
   logic [15:0] s_alu;
   logic [4:0]  s_rd;
   logic        s_rw;
   logic [15:0] s_hi;
   logic [15:0] s_lo;
   logic [1:0]  s_state;

   ex_stage_mdu #(.XLEN(16)) dut16 (
      .clk_i(clk_i), .n_rst_i(n_rst_i), .flush_i(1'b0),
      .IDEX_valid_i(s_valid_i), .IDEX_op_i(OP_R), .IDEX_aux_i(ALU_MULT),
      .IDEX_shift_i(5'd0), .IDEX_a_i(s_a), .IDEX_b_i(s_b),
      .IDEX_imm_i(16'd0), .IDEX_alu_src_i(1'b0), .IDEX_rd_i(5'd0),
      .IDEX_reg_write_i(1'b0), .busy_o(s_busy),
      .EXMEM_valid_o(s_valid_o), .EXMEM_alu_o(s_alu), .EXMEM_rd_o(s_rd),
      .EXMEM_reg_write_o(s_rw), .hi_o(s_hi), .lo_o(s_lo),
      .dbg_state_o(s_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [4:0] aux,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] imm, input logic src,
                        input logic [4:0] sh, input logic [4:0] rd);
      IDEX_valid_i     = 1'b1;
      IDEX_op_i        = op;
      IDEX_aux_i       = aux;
      IDEX_a_i         = a;
      IDEX_b_i         = b;
      IDEX_imm_i       = imm;
      IDEX_alu_src_i   = src;
      IDEX_shift_i     = sh;
      IDEX_rd_i        = rd;
      IDEX_reg_write_i = 1'b1;
   endtask

   task automatic idle_in();
      IDEX_valid_i     = 1'b0;
      IDEX_reg_write_i = 1'b0;
   endtask

   // Accept an MDU op at the next edge, then release ID/EX
   task automatic start_mdu(input logic [4:0] aux, input logic [31:0] a, input logic [31:0] b);
      drive(OP_R, aux, a, b, 16'd0, 1'b0, 5'd0, 5'd3);
      step();
      idle_in();
   endtask

   // Count samples with busy high; ends on the first sample after busy falls
   task automatic wait_busy(output int n);
      int g;
      n = 0;
      g = 0;
      while (busy_o && g < 100) begin
         n++;
         check("bubble_while_busy", {63'd0, EXMEM_valid_o}, 64'd0);
         step();
         g++;
      end
      if (g >= 100) check("busy_timeout", 64'd1, 64'd0);
   endtask

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  aux;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm;
      logic        src;
      logic [4:0]  sh;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[16];
   int   n;

   initial begin
      vt[0]  = '{OP_R,    AUX_ADD,  32'd5,        32'd7,        16'h0000, 1'b0, 5'd0,  32'h0000000C};
      vt[1]  = '{OP_R,    AUX_SUB,  32'd3,        32'd5,        16'h0000, 1'b0, 5'd0,  32'hFFFFFFFE};
      vt[2]  = '{OP_R,    AUX_ADD,  32'hFFFFFFFF, 32'd2,        16'h0000, 1'b0, 5'd0,  32'h00000001};
      vt[3]  = '{OP_R,    AUX_AND,  32'hFFFF0000, 32'h0F0F0F0F, 16'h0000, 1'b0, 5'd0,  32'h0F0F0000};
      vt[4]  = '{OP_R,    AUX_OR,   32'h00FF0000, 32'h000000FF, 16'h0000, 1'b0, 5'd0,  32'h00FF00FF};
      vt[5]  = '{OP_R,    AUX_XOR,  32'hFFFF0000, 32'hFF00FF00, 16'h0000, 1'b0, 5'd0,  32'h00FFFF00};
      vt[6]  = '{OP_R,    AUX_NOR,  32'h0F0F0F0F, 32'hF0F00000, 16'h0000, 1'b0, 5'd0,  32'h0000F0F0};
      vt[7]  = '{OP_R,    AUX_SLL,  32'd0,        32'd1,        16'h0000, 1'b0, 5'd4,  32'h00000010};
      vt[8]  = '{OP_R,    AUX_SRL,  32'd0,        32'h80000000, 16'h0000, 1'b0, 5'd31, 32'h00000001};
      vt[9]  = '{OP_R,    AUX_SRA,  32'd0,        32'h80000000, 16'h0000, 1'b0, 5'd4,  32'hF8000000};
      vt[10] = '{OP_ADDI, AUX_ADD,  32'd10,       32'd0,        16'hFFFF, 1'b1, 5'd0,  32'h00000009};
      vt[11] = '{OP_ORI,  AUX_ADD,  32'd0,        32'd0,        16'h8000, 1'b1, 5'd0,  32'hFFFF8000};
      vt[12] = '{OP_ANDI, AUX_ADD,  32'hFFFFFFFF, 32'd0,        16'h00F0, 1'b1, 5'd0,  32'h000000F0};
      vt[13] = '{OP_XORI, AUX_ADD,  32'h0F0F0F0F, 32'd0,        16'hFFFF, 1'b1, 5'd0,  32'hF0F0F0F0};
      vt[14] = '{OP_R,    5'd31,    32'd1,        32'd1,        16'h0000, 1'b0, 5'd0,  32'hFFFFFFFF};
      vt[15] = '{6'h3F,   AUX_ADD,  32'd1,        32'd1,        16'h0000, 1'b0, 5'd0,  32'hFFFFFFFF};

      // reset state
      #2;
      check("rst_busy",  {63'd0, busy_o}, 64'd0);
      check("rst_valid", {63'd0, EXMEM_valid_o}, 64'd0);
      check("rst_hi",    {32'd0, hi_o}, 64'd0);
      check("rst_lo",    {32'd0, lo_o}, 64'd0);
      check("rst_state", {62'd0, dbg_state_o}, 64'd0);
      #10 n_rst_i = 1'b1;
      step();

      // back-to-back ALU ops, one result per cycle
      for (int i = 0; i < 16; i++) begin
         drive(vt[i].op, vt[i].aux, vt[i].a, vt[i].b, vt[i].imm, vt[i].src, vt[i].sh, 5'(i + 1));
         exp_q.push_back(vt[i].exp);
         step();
         check($sformatf("alu_valid_%0d", i), {63'd0, EXMEM_valid_o}, 64'd1);
         check($sformatf("alu_res_%0d", i), {32'd0, EXMEM_alu_o}, {32'd0, exp_q.pop_front()});
         check($sformatf("alu_rd_%0d", i), {59'd0, EXMEM_rd_o}, 64'(i + 1));
         check($sformatf("alu_busy_%0d", i), {63'd0, busy_o}, 64'd0);
      end
      idle_in();
      step();
      check("idle_bubble", {63'd0, EXMEM_valid_o}, 64'd0);
      check("idle_rw", {63'd0, EXMEM_reg_write_o}, 64'd0);

      // signed multiply: -2 * 3
      start_mdu(ALU_MULT, 32'hFFFFFFFE, 32'd3);
      wait_busy(n);
      check("mult_busy_cycles", 64'(n), 64'd32);
      check("mult_hi", {32'd0, hi_o}, 64'hFFFFFFFF);
      check("mult_lo", {32'd0, lo_o}, 64'hFFFFFFFA);

      // unsigned multiply of all-ones operands
      start_mdu(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_busy(n);
      check("multu_hi", {32'd0, hi_o}, 64'hFFFFFFFE);
      check("multu_lo", {32'd0, lo_o}, 64'h00000001);

      // DIVU 100/7 with MFLO held in ID/EX, then MFHI
      start_mdu(ALU_DIVU, 32'd100, 32'd7);
      drive(OP_R, AUX_MFLO, 32'd0, 32'd0, 16'd0, 1'b0, 5'd0, 5'd9);
      wait_busy(n);
      check("divu_busy_cycles", 64'(n), 64'd32);
      check("mflo_not_early", {63'd0, EXMEM_valid_o}, 64'd0);
      check("divu_lo", {32'd0, lo_o}, 64'd14);
      check("divu_hi", {32'd0, hi_o}, 64'd2);
      step();
      check("mflo_valid", {63'd0, EXMEM_valid_o}, 64'd1);
      check("mflo_res", {32'd0, EXMEM_alu_o}, 64'h0000000E);
      drive(OP_R, AUX_MFHI, 32'd0, 32'd0, 16'd0, 1'b0, 5'd0, 5'd10);
      step();
      check("mfhi_res", {32'd0, EXMEM_alu_o}, 64'h00000002);
      idle_in();

      // signed divide -7 / 2
      start_mdu(ALU_DIV, 32'hFFFFFFF9, 32'd2);
      wait_busy(n);
      check("div_neg_lo", {32'd0, lo_o}, 64'hFFFFFFFD);
      check("div_neg_hi", {32'd0, hi_o}, 64'hFFFFFFFF);

      // signed overflow: most-negative / -1
      start_mdu(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_busy(n);
      check("div_ovf_lo", {32'd0, lo_o}, 64'h80000000);
      check("div_ovf_hi", {32'd0, hi_o}, 64'h00000000);

      // divide by zero still takes the full latency
      start_mdu(ALU_DIV, 32'h00001234, 32'd0);
      wait_busy(n);
      check("div0_cycles", 64'(n), 64'd32);
      check("div0_lo", {32'd0, lo_o}, 64'hFFFFFFFF);
      check("div0_hi", {32'd0, hi_o}, 64'h00001234);

      // flush aborts an in-flight MULTU at cycle 10
      start_mdu(ALU_MULTU, 32'd3, 32'd5);
      for (int i = 0; i < 9; i++) step();
      check("pre_flush_busy", {63'd0, busy_o}, 64'd1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("flush_busy", {63'd0, busy_o}, 64'd0);
      check("flush_state", {62'd0, dbg_state_o}, 64'd0);
      check("flush_hi", {32'd0, hi_o}, 64'h00001234);
      check("flush_lo", {32'd0, lo_o}, 64'hFFFFFFFF);
      for (int i = 0; i < 30; i++) step();
      check("flush_hi_later", {32'd0, hi_o}, 64'h00001234);

      // flush beats acceptance at the same edge
      drive(OP_R, AUX_ADD, 32'd1, 32'd2, 16'd0, 1'b0, 5'd0, 5'd4);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("flush_prio_valid", {63'd0, EXMEM_valid_o}, 64'd0);
      step();
      idle_in();
      check("after_flush_valid", {63'd0, EXMEM_valid_o}, 64'd1);
      check("after_flush_res", {32'd0, EXMEM_alu_o}, 64'd3);

      // asynchronous reset at cycle 20 of a MULTU
      start_mdu(ALU_MULTU, 32'd7, 32'd9);
      for (int i = 0; i < 19; i++) step();
      #2 n_rst_i = 1'b0;
      #1;
      check("arst_busy",  {63'd0, busy_o}, 64'd0);
      check("arst_hi",    {32'd0, hi_o}, 64'd0);
      check("arst_lo",    {32'd0, lo_o}, 64'd0);
      check("arst_state", {62'd0, dbg_state_o}, 64'd0);
      check("arst_valid", {63'd0, EXMEM_valid_o}, 64'd0);
      #2 n_rst_i = 1'b1;
      for (int i = 0; i < 15; i++) step();
      check("post_rst_busy", {63'd0, busy_o}, 64'd0);
      check("post_rst_lo", {32'd0, lo_o}, 64'd0);

      // 16-bit build: 0x8000 * 0x8000 signed
      s_a = 16'h8000;
      s_b = 16'h8000;
      s_valid_i = 1'b1;
      step();
      s_valid_i = 1'b0;
      n = 0;
      for (int g = 0; g < 100 && s_busy; g++) begin
         n++;
         step();
      end
      check("m16_cycles", 64'(n), 64'd16);
      check("m16_hi", {48'd0, s_hi}, 64'h4000);
      check("m16_lo", {48'd0, s_lo}, 64'h0000);
      check("m16_valid", {63'd0, s_valid_o}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
